gray_conv_arbiter: RTL and testbench

//  Time-shares one Gray<->binary conversion datapath among NUM_REQ requesters.

---
 rtl/gray_conv_arbiter_pkg.sv | 34 +++
 rtl/gray_conv_arbiter_if.sv | 28 ++
 rtl/gray_conv_arbiter_rr.sv | 50 +++++
 rtl/gray_conv_arbiter.sv | 124 ++++++++++++
 tb/tb_gray_conv_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and conversion helpers for the Gray<->binary conversion arbiter.
// Optional conversion counter is enabled by defining GC_CONV_CNT_EN (see top).
package gray_conv_pkg;

  // Widest operand the helpers accept; narrower operands are zero-extended,
  // which leaves both conversions unchanged in the low bits.
  localparam int unsigned GC_MAX_W = 32;

  typedef enum logic {
    GC_G2B = 1'b0,
    GC_B2G = 1'b1
  } conv_mode_e;

  typedef enum logic {
    GC_EMPTY = 1'b0,
    GC_FULL  = 1'b1
  } out_state_e;

  function automatic logic [GC_MAX_W-1:0] bin2gray(input logic [GC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the running XOR of the Gray bits from the MSB down.
  function automatic logic [GC_MAX_W-1:0] gray2bin(input logic [GC_MAX_W-1:0] g);
    logic [GC_MAX_W-1:0] b;
    b = '0;
    b[GC_MAX_W-1] = g[GC_MAX_W-1];
    for (int unsigned i = 1; i < GC_MAX_W; i++) begin
      b[GC_MAX_W-1-i] = b[GC_MAX_W-i] ^ g[GC_MAX_W-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Request/result bus of the conversion arbiter.
// master: requesters + result consumer side; slave: the arbiter itself.
interface gray_conv_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned NUM_REQ    = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_mode;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [IDW-1:0]                out_id;

  modport master (
    output req_valid, req_mode, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_mode, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/gray_conv_arbiter_rr.sv
// Round-robin arbiter: owns the rotating priority pointer and produces a
// one-hot grant plus its index. The pointer moves past the granted requester
// only when the top reports an actual transfer.
module gray_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               advance,
  input  logic [IDW-1:0]     advance_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic [IDW-1:0] r_ptr;
  logic [31:0]    w_sum;
  logic [IDW-1:0] w_cand;
  logic           w_found;

  // First valid requester searching upward from the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_sum = 32'(r_ptr) + off;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_cand = IDW'(w_sum);
      if (!w_found && req_valid[w_cand]) begin
        w_found        = 1'b1;
        grant[w_cand]  = 1'b1;
        grant_idx      = w_cand;
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (32'(advance_idx) == NUM_REQ - 1) ? '0 : advance_idx + 1'b1;
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Time-shares one Gray<->binary converter among NUM_REQ requesters with a
// single-entry result register (EMPTY/FULL) and valid/ready on both sides.
// Define GC_CONV_CNT_EN to add the conv_count port counting accepted results.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_conv_arbiter_if.slave  bus
`ifdef GC_CONV_CNT_EN
  ,
  output logic [15:0]         conv_count
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  out_state_e            r_state;
  out_state_e            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDW-1:0]        r_id;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDW-1:0]        w_grant_idx;
  logic                  w_can_accept;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_operand;
  conv_mode_e            w_mode;
  logic [DATA_WIDTH-1:0] w_result;

  gray_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (bus.req_valid),
    .advance     (w_xfer),
    .advance_idx (w_grant_idx),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx)
  );

  // Select the granted requester's operand and mode.
  always_comb begin
    w_operand = '0;
    w_mode    = GC_G2B;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_operand = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_mode    = conv_mode_e'(bus.req_mode[i]);
      end
    end
  end

  // Shared conversion datapath.
  always_comb begin
    w_result = '0;
    if (w_mode == GC_B2G) begin
      w_result = DATA_WIDTH'(bin2gray(GC_MAX_W'(w_operand)));
    end else begin
      w_result = DATA_WIDTH'(gray2bin(GC_MAX_W'(w_operand)));
    end
  end

  // Output-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: fill on a transfer, drain when the consumer takes the result
  // and nothing replaces it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      GC_EMPTY: if (w_xfer) w_state_nxt = GC_FULL;
      GC_FULL:  if (bus.out_ready && !w_xfer) w_state_nxt = GC_EMPTY;
      default:  w_state_nxt = GC_EMPTY;
    endcase
  end

  // Handshake outputs; ready is held low while reset is asserted.
  always_comb begin
    bus.out_valid = (r_state == GC_FULL);
    w_can_accept  = rst_n && ((r_state == GC_EMPTY) || bus.out_ready);
    bus.req_ready = w_grant & {NUM_REQ{w_can_accept}};
    w_xfer        = w_can_accept && (|w_grant);
    bus.out_data  = r_data;
    bus.out_id    = r_id;
  end

  // Result register: loads only on a transfer, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_id   <= '0;
    end else if (w_xfer) begin
      r_data <= w_result;
      r_id   <= w_grant_idx;
    end
  end

`ifdef GC_CONV_CNT_EN
  logic [15:0] r_conv_count;

  // Count results taken by the consumer; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_count <= '0;
    end else if ((r_state == GC_FULL) && bus.out_ready) begin
      r_conv_count <= r_conv_count + 16'd1;
    end
  end

  assign conv_count = r_conv_count;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter (DATA_WIDTH=4, NUM_REQ=4): directed scenarios
// followed by random traffic, compared against a transaction-level model.
module tb_gray_conv_arbiter;

  localparam int DW = 4;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

`ifdef GC_CONV_CNT_EN
  logic [15:0] conv_count;
`endif

  gray_conv_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef GC_CONV_CNT_EN
    ,
    .conv_count (conv_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_full;
  logic [3:0]  m_data;
  int          m_id;
  int          m_ptr;
  int          last_xfer;
  logic [15:0] m_cnt;

  function automatic logic [3:0] ref_g2b(input logic [3:0] g);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic logic [3:0] ref_b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int off = 0; off < NR; off++) begin
      int idx;
      idx = (m_ptr + off) % NR;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full    = 1'b0;
    m_ptr     = 0;
    m_cnt     = '0;
    last_xfer = -1;
  endtask

  task automatic set_req(input int i, input bit v, input bit mode, input logic [3:0] d);
    bus.req_valid[i]        = v;
    bus.req_mode[i]         = mode;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic tick();
    int         gi;
    bit         can;
    logic [3:0] exp_rdy;
    logic [3:0] opnd;
    #1;
    can     = rst_n && (!m_full || bus.out_ready);
    gi      = pick();
    exp_rdy = (can && gi >= 0) ? 4'(1 << gi) : 4'b0000;
    chk("req_ready", bus.req_ready, exp_rdy);
    @(posedge clk);
    last_xfer = -1;
    if (rst_n) begin
      if (m_full && bus.out_ready) m_cnt = m_cnt + 16'd1;
      if (exp_rdy != 4'b0000) begin
        opnd      = bus.req_data[gi*DW +: DW];
        m_data    = bus.req_mode[gi] ? ref_b2g(opnd) : ref_g2b(opnd);
        m_id      = gi;
        m_full    = 1'b1;
        m_ptr     = (gi + 1) % NR;
        last_xfer = gi;
      end else if (m_full && bus.out_ready) begin
        m_full = 1'b0;
      end
    end
    #1;
    chk("out_valid", bus.out_valid, m_full);
    if (m_full) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_id", bus.out_id, m_id);
    end
`ifdef GC_CONV_CNT_EN
    chk("conv_count", conv_count, m_cnt);
`endif
  endtask

  // Served requester presents a fresh random request, still valid.
  task automatic refresh_busy();
    if (last_xfer >= 0) set_req(last_xfer, 1'b1, 1'($urandom % 2), 4'($urandom));
  endtask

  // Idle or just-served requesters may change freely; pending ones hold.
  task automatic refresh_random();
    for (int i = 0; i < NR; i++) begin
      if (i == last_xfer || !bus.req_valid[i])
        set_req(i, 1'($urandom % 2), 1'($urandom % 2), 4'($urandom));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] hold_data;
    int         hold_id;

    bus.req_valid = '0;
    bus.req_mode  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state, even with every requester asking
    #12;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 4'b0000);
    chk("rst_id", bus.out_id, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: Gray->binary on requester 0
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'b1011);
    tick();
    chk("t1_valid", bus.out_valid, 1'b1);
    chk("t1_data", bus.out_data, 4'b1101);
    chk("t1_id", bus.out_id, 0);

    // 2: binary->Gray on requester 2, then Gray corner values
    set_req(0, 1'b0, 1'b0, 4'b0000);
    set_req(2, 1'b1, 1'b1, 4'b1101);
    tick();
    chk("t2_b2g_data", bus.out_data, 4'b1011);
    chk("t2_b2g_id", bus.out_id, 2);
    set_req(2, 1'b0, 1'b0, 4'b0000);
    set_req(1, 1'b1, 1'b0, 4'b1000);
    tick();
    chk("t2_g1000", bus.out_data, 4'b1111);
    set_req(1, 1'b0, 1'b0, 4'b0000);
    set_req(3, 1'b1, 1'b0, 4'b0000);
    tick();
    chk("t2_g0000", bus.out_data, 4'b0000);
    chk("t2_g0000_id", bus.out_id, 3);

    // 3: all requesters busy, one result per cycle in rotating order
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'($urandom % 2), 4'($urandom));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_rr_id", bus.out_id, k % NR);
      chk("t3_valid", bus.out_valid, 1'b1);
      refresh_busy();
    end

    // 4: consumer stall while FULL, then release
    hold_data = m_data;
    hold_id   = m_id;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stall_ready", bus.req_ready, 4'b0000);
      chk("t4_stall_data", bus.out_data, hold_data);
      chk("t4_stall_id", bus.out_id, hold_id);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_release_ready", bus.req_ready, 4'b0010);
    tick();
    chk("t4_release_id", bus.out_id, 1);
    refresh_busy();

    // 5: asynchronous reset while a result is pending
    tick();
    refresh_busy();
    chk("t5_pre_valid", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", bus.out_valid, 1'b0);
    chk("t5_async_data", bus.out_data, 4'b0000);
    chk("t5_async_id", bus.out_id, 0);
    chk("t5_async_ready", bus.req_ready, 4'b0000);
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5_first_id", bus.out_id, 0);
    refresh_busy();

    // Random traffic with random back-pressure
    for (int k = 0; k < 300; k++) begin
      bus.out_ready = ($urandom % 4) != 0;
      refresh_random();
      tick();
    end

`ifdef GC_CONV_CNT_EN
    // 6: counter wrap under continuous traffic
    bus.out_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (!bus.req_valid[i]) set_req(i, 1'b1, 1'($urandom % 2), 4'($urandom));
    end
    for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) begin
      tick();
      refresh_busy();
    end
    chk("t6_cnt_ffff", conv_count, 16'hFFFF);
    tick();
    chk("t6_cnt_wrap", conv_count, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
